// File: rtl/pingpong_resp_ctrl.sv
// pingpong_resp_ctrl: answers each toggle of hps_ping with one toggle of
// fpga_pong after a programmable delay. It also counts completed exchanges
// and runs a heartbeat watchdog.
// Optional build macro PINGPONG_OVERRUN_EN adds the sticky overrun flag
// for pings dropped while busy.
module pingpong_resp_ctrl #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned DLY_W       = 8,
    parameter int unsigned TO_W        = 26,
    parameter int unsigned TIMEOUT_CYC = 50000000
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic             hps_ping,
    output logic             fpga_pong,
    input  logic             enable,
    input  logic [DLY_W-1:0] resp_delay,
    input  logic             flags_clr,
    output logic             busy,
    output logic             ping_seen,
    output logic [CNT_W-1:0] ping_count,
    output logic             timeout,
    output logic             overrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        REPLY = 2'd2
    } state_t;

    localparam logic [TO_W-1:0] WD_MAX = TO_W'(TIMEOUT_CYC - 1);

    logic             s1, s2, s3;
    logic             ev_c;
    state_t           state_q, state_d;
    logic [DLY_W-1:0] dcnt_q, dcnt_d;
    logic             pong_q, pong_d;
    logic             seen_q, seen_d;
    logic             busy_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TO_W-1:0]  wcnt_q, wcnt_d;
    logic             timeout_q, timeout_d;

    // Three-flop synchroniser; a level change between s2 and s3 is one ping
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= hps_ping;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign ev_c = s2 ^ s3;

    // State and registered outputs
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q   <= IDLE;
            dcnt_q    <= '0;
            pong_q    <= 1'b0;
            seen_q    <= 1'b0;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            wcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dcnt_q    <= dcnt_d;
            pong_q    <= pong_d;
            seen_q    <= seen_d;
            busy_q    <= (state_d != IDLE);
            cnt_q     <= cnt_d;
            wcnt_q    <= wcnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic: accept a ping, count down the delay, then toggle pong
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        pong_d  = pong_q;
        seen_d  = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (enable && ev_c) begin
                    dcnt_d  = resp_delay;
                    seen_d  = 1'b1;
                    state_d = DELAY;
                end
            end
            DELAY: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (dcnt_q == '0) begin
                    state_d = REPLY;
                end else begin
                    dcnt_d = dcnt_q - DLY_W'(1);
                end
            end
            REPLY: begin
                pong_d  = ~pong_q;
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Heartbeat watchdog: count silent enabled cycles, saturate, raise timeout
    always_comb begin
        wcnt_d    = wcnt_q;
        timeout_d = timeout_q;
        if (!enable || flags_clr || ev_c) begin
            wcnt_d = '0;
        end else if (wcnt_q != WD_MAX) begin
            wcnt_d = wcnt_q + TO_W'(1);
        end
        if (enable && !ev_c && (wcnt_q == WD_MAX)) begin
            timeout_d = 1'b1;
        end
        if (flags_clr) begin
            timeout_d = 1'b0;
        end
    end

`ifdef PINGPONG_OVERRUN_EN
    logic ovr_q;

    // Sticky flag for a ping that arrives while an exchange is in flight
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            ovr_q <= 1'b0;
        end else if (flags_clr) begin
            ovr_q <= 1'b0;
        end else if (enable && ev_c && (state_q != IDLE)) begin
            ovr_q <= 1'b1;
        end
    end

    assign overrun = ovr_q;
`else
    assign overrun = 1'b0;
`endif

    assign fpga_pong  = pong_q;
    assign ping_seen  = seen_q;
    assign busy       = busy_q;
    assign ping_count = cnt_q;
    assign timeout    = timeout_q;

endmodule
